// File: rtl/conv_addr_fsm.sv
// Convolution column-buffer address sequencer: fills N_BANKS column banks, then streams reads.
// Define CONV_ADDR_FSM_BACKPRESSURE_EN to let i_convReady stall read issue.
module conv_addr_fsm #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int N_BANKS    = 3
) (
  input  logic                       i_CLK,
  input  logic                       i_reset,
  input  logic                       i_SoP,
  input  logic [NB_IMAGE-1:0]        i_imgLength,
  input  logic                       i_valid,
  input  logic                       i_convReady,
  output logic [NB_ADDRESS-1:0]      o_writeAdd,
  output logic                       o_writeEn,
  output logic [NB_ADDRESS-1:0]      o_readAdd,
  output logic [$clog2(N_BANKS)-1:0] o_bankSel,
  output logic                       o_fsm2convVld,
  output logic                       o_changeBlock,
  output logic                       o_EoP,
  output logic                       o_busy
);

  localparam int BW = $clog2(N_BANKS);
  localparam int QW = $clog2(N_BANKS + 1);
  localparam logic [NB_IMAGE-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [NB_IMAGE-1:0] len_q, len_d;
  logic [NB_IMAGE-1:0] widx_q, widx_d;
  logic [NB_IMAGE-1:0] ridx_q, ridx_d;
  logic [NB_IMAGE-1:0] col_q, col_d;
  logic [QW-1:0]       quota_q, quota_d;
  logic [BW-1:0]       bank_q, bank_d;

  logic [NB_ADDRESS-1:0] wadd_d, radd_d;
  logic [BW-1:0]         bsel_d;
  logic wen_d, vld_d, chg_d, eop_d, busy_d;
  logic rdy;

  logic [NB_IMAGE-1:0] last_idx;
  logic [NB_IMAGE-1:0] n_cols;
  logic [NB_IMAGE-1:0] col_inc;
  logic [BW-1:0]       bank_nxt;

`ifdef CONV_ADDR_FSM_BACKPRESSURE_EN
  assign rdy = i_convReady;
`else
  logic unused_ready;
  assign unused_ready = i_convReady;
  assign rdy = 1'b1;
`endif

  // a picture of side L yields L-N_BANKS+1 output columns
  assign last_idx = len_q - ONE;
  assign n_cols   = len_q - NB_IMAGE'(N_BANKS - 1);
  assign col_inc  = col_q + ONE;
  assign bank_nxt = (bank_q == BW'(N_BANKS - 1)) ? '0 : bank_q + BW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    col_d   = col_q;
    quota_d = quota_q;
    bank_d  = bank_q;
    wadd_d  = o_writeAdd;
    radd_d  = o_readAdd;
    bsel_d  = '0;
    wen_d   = 1'b0;
    vld_d   = 1'b0;
    chg_d   = 1'b0;
    eop_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_SoP) begin
          len_d   = i_imgLength;
          widx_d  = '0;
          ridx_d  = '0;
          col_d   = '0;
          bank_d  = '0;
          quota_d = QW'(N_BANKS);
          if (i_imgLength >= NB_IMAGE'(N_BANKS))
            state_d = FILL;
          else
            state_d = DONE;
        end
      end
      FILL: begin
        bsel_d = bank_q;
        if (i_valid) begin
          wen_d  = 1'b1;
          wadd_d = NB_ADDRESS'(widx_q);
          if (widx_q == last_idx) begin
            widx_d  = '0;
            chg_d   = 1'b1;
            bank_d  = bank_nxt;
            quota_d = quota_q - QW'(1);
            if (quota_q == QW'(1)) begin
              state_d = RUN;
              ridx_d  = '0;
            end
          end else begin
            widx_d = widx_q + ONE;
          end
        end
      end
      RUN: begin
        bsel_d = bank_q;
        radd_d = NB_ADDRESS'(ridx_q);
        if (rdy) begin
          vld_d = 1'b1;
          if (ridx_q == last_idx) begin
            ridx_d = '0;
            col_d  = col_inc;
            if (col_inc == n_cols) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
              quota_d = QW'(1);
              widx_d  = '0;
            end
          end else begin
            ridx_d = ridx_q + ONE;
          end
        end
      end
      DONE: begin
        eop_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      widx_q        <= '0;
      ridx_q        <= '0;
      col_q         <= '0;
      quota_q       <= '0;
      bank_q        <= '0;
      o_writeAdd    <= '0;
      o_writeEn     <= 1'b0;
      o_readAdd     <= '0;
      o_bankSel     <= '0;
      o_fsm2convVld <= 1'b0;
      o_changeBlock <= 1'b0;
      o_EoP         <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      widx_q        <= widx_d;
      ridx_q        <= ridx_d;
      col_q         <= col_d;
      quota_q       <= quota_d;
      bank_q        <= bank_d;
      o_writeAdd    <= wadd_d;
      o_writeEn     <= wen_d;
      o_readAdd     <= radd_d;
      o_bankSel     <= bsel_d;
      o_fsm2convVld <= vld_d;
      o_changeBlock <= chg_d;
      o_EoP         <= eop_d;
      o_busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_conv_addr_fsm.sv
// Scoreboard bench for conv_addr_fsm: expected write/read/EoP events
// are queued per picture and popped as the DUT emits them.
module tb_conv_addr_fsm;

  localparam int NA = 10;
  localparam int NI = 10;
  localparam int NB = 3;
  localparam int BW = $clog2(NB);

  typedef struct {
    int kind;
    int addr;
    int bank;
  } ev_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_SoP;
  logic [NI-1:0] i_imgLength;
  logic          i_valid;
  logic          i_convReady;
  logic [NA-1:0] o_writeAdd;
  logic          o_writeEn;
  logic [NA-1:0] o_readAdd;
  logic [BW-1:0] o_bankSel;
  logic          o_fsm2convVld;
  logic          o_changeBlock;
  logic          o_EoP;
  logic          o_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_addr_fsm #(
    .NB_ADDRESS(NA),
    .NB_IMAGE(NI),
    .N_BANKS(NB)
  ) dut (
    .i_CLK(clk),
    .i_reset(i_reset),
    .i_SoP(i_SoP),
    .i_imgLength(i_imgLength),
    .i_valid(i_valid),
    .i_convReady(i_convReady),
    .o_writeAdd(o_writeAdd),
    .o_writeEn(o_writeEn),
    .o_readAdd(o_readAdd),
    .o_bankSel(o_bankSel),
    .o_fsm2convVld(o_fsm2convVld),
    .o_changeBlock(o_changeBlock),
    .o_EoP(o_EoP),
    .o_busy(o_busy)
  );

  task automatic test_reset();
    logic [2*NA+BW+5-1:0] all_o;
    i_reset = 1'b1;
    i_SoP = 1'b1;
    i_imgLength = NI'(4);
    i_valid = 1'b1;
    i_convReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_o = {o_writeAdd, o_writeEn, o_readAdd, o_bankSel,
             o_fsm2convVld, o_changeBlock, o_EoP, o_busy};
    n_cmp++;
    if (all_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", all_o);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_SoP = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_priority busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_short(input int len);
    @(posedge clk); #1;
    i_SoP = 1'b1;
    i_imgLength = NI'(len);
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      i_SoP = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_EoP !== (i == 1) || o_busy !== (i == 0) ||
          o_writeEn !== 1'b0 || o_fsm2convVld !== 1'b0) begin
        n_err++;
        $display("FAIL short_L%0d cyc%0d got eop=%b busy=%b wen=%b vld=%b want eop=%b busy=%b wen=0 vld=0",
                 len, i, o_EoP, o_busy, o_writeEn, o_fsm2convVld, i == 1, i == 0);
      end
    end
    i_valid = 1'b0;
  endtask

  // mode 0: continuous valid; 1: toggling valid plus SoP/length noise;
  // 2: three-cycle ready stall at read index 2; 3: random ready (ignored)
  task automatic test_picture(input int len, input int mode);
    ev_t q[$];
    ev_t e;
    int chg, post, hc, sc, k;
    bit eop_seen, armed;
    logic pv;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < len; a++) q.push_back('{0, a, b});
    for (int c = 0; c <= len - NB; c++) begin
      for (int a = 0; a < len; a++) q.push_back('{1, a, c % NB});
      if (c < len - NB)
        for (int a = 0; a < len; a++) q.push_back('{0, a, c % NB});
    end
    q.push_back('{2, 0, 0});
    @(posedge clk); #1;
    i_SoP = 1'b1;
    i_imgLength = NI'(len);
    i_valid = 1'b0;
    i_convReady = 1'b1;
    chg = 0; post = 0; hc = -1; sc = 0;
    eop_seen = 0; armed = 0;
    for (int it = 0; it < 4000 && post < 4; it++) begin
      @(posedge clk); #1;
      i_SoP = (mode == 1 && q.size() > 1) ? 1'($urandom % 2) : 1'b0;
      if (mode == 1) i_imgLength = NI'($urandom);
      pv = i_valid;
      i_valid = (mode == 1) ? ~it[0] : 1'b1;
      if (mode == 2) begin
        if (sc > 0) begin
          i_convReady = 1'b0;
          sc--;
        end else begin
          i_convReady = 1'b1;
        end
      end else if (mode == 3) begin
        i_convReady = 1'($urandom % 2);
      end else begin
        i_convReady = 1'b1;
      end
      @(negedge clk);
      if (o_changeBlock === 1'b1) chg++;
      if (mode == 1 && it >= 1 && it <= 2 * NB * len - 1) begin
        n_cmp++;
        if (o_writeEn !== pv) begin
          n_err++;
          $display("FAIL wen_mirror it%0d got %b want %b", it, o_writeEn, pv);
        end
      end
      if (hc >= 0) hc++;
      if (hc >= 2 && hc <= 5) begin
        n_cmp++;
        if (o_readAdd !== NA'(2) || o_fsm2convVld !== (hc == 5)) begin
          n_err++;
          $display("FAIL stall hc%0d got add=%0d vld=%b want add=2 vld=%b",
                   hc, o_readAdd, o_fsm2convVld, hc == 5);
        end
      end
      if (o_writeEn === 1'b1 || o_fsm2convVld === 1'b1 || o_EoP === 1'b1) begin
        k = (o_writeEn === 1'b1) ? 0 : (o_fsm2convVld === 1'b1) ? 1 : 2;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL event_L%0d unexpected kind %0d wadd=%0d radd=%0d", len, k,
                   o_writeAdd, o_readAdd);
        end else begin
          e = q.pop_front();
          if (e.kind != k ||
              (k == 0 && (int'(o_writeAdd) != e.addr || int'(o_bankSel) != e.bank)) ||
              (k == 1 && (int'(o_readAdd) != e.addr || int'(o_bankSel) != e.bank)) ||
              (k == 2 && o_busy !== 1'b0) ||
              (int'(o_writeEn) + int'(o_fsm2convVld) + int'(o_EoP) != 1)) begin
            n_err++;
            $display("FAIL event_L%0d got kind=%0d wadd=%0d radd=%0d bank=%0d busy=%b want kind=%0d addr=%0d bank=%0d",
                     len, k, o_writeAdd, o_readAdd, o_bankSel, o_busy,
                     e.kind, e.addr, e.bank);
          end
        end
        if (mode == 2 && !armed && k == 1 && o_readAdd === '0) begin
          armed = 1;
          sc = 3;
          hc = 0;
        end
        if (k == 2) eop_seen = 1;
      end
      if (eop_seen) post++;
    end
    i_SoP = 1'b0;
    i_valid = 1'b0;
    i_convReady = 1'b1;
    i_imgLength = NI'(len);
    n_cmp++;
    if (!eop_seen || q.size() != 0) begin
      n_err++;
      $display("FAIL done_L%0d got eop_seen=%0d left=%0d want 1 and 0", len, eop_seen, q.size());
    end
    n_cmp++;
    if (chg != len) begin
      n_err++;
      $display("FAIL changeblock_L%0d got %0d want %0d", len, chg, len);
    end
    if (mode == 2) begin
      n_cmp++;
      if (hc < 5) begin
        n_err++;
        $display("FAIL stall_reached got hc=%0d want >=5", hc);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2*NA+BW+5-1:0] all_o;
    bit seen;
    @(posedge clk); #1;
    i_SoP = 1'b1;
    i_imgLength = NI'(4);
    i_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      i_SoP = 1'b0;
      @(negedge clk);
      if (o_fsm2convVld === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL midrun_reach got no read want read within 60 cycles");
    end
    @(posedge clk); #1;
    i_reset = 1'b1;
    i_SoP = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    all_o = {o_writeAdd, o_writeEn, o_readAdd, o_bankSel,
             o_fsm2convVld, o_changeBlock, o_EoP, o_busy};
    n_cmp++;
    if (all_o !== '0) begin
      n_err++;
      $display("FAIL midrun_reset got %h want 0", all_o);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_SoP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_EoP !== 1'b0 || o_busy !== 1'b0 || o_writeEn !== 1'b0) begin
        n_err++;
        $display("FAIL aborted_pic cyc%0d got eop=%b busy=%b wen=%b want 0 0 0",
                 i, o_EoP, o_busy, o_writeEn);
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short(2);
    test_short(0);
    test_picture(4, 0);
    test_picture(15, 1);
`ifdef CONV_ADDR_FSM_BACKPRESSURE_EN
    test_picture(4, 2);
`else
    test_picture(4, 3);
`endif
    test_reset_mid_run();
    test_picture(4, 0);
    test_picture(6, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_addr_fsm.md
CONV_ADDR_FSM -- requirements
Module: conv_addr_fsm

Interface
REQ-001 Parameter NB_ADDRESS, default 10: width of memory address outputs.
REQ-002 Parameter NB_IMAGE, default 10: width of image length input and internal column counters.
REQ-003 Parameter N_BANKS, default 3: number of column memory banks, equal to kernel width; legal range 2..8.
REQ-004 Port i_CLK  input  1  single clock; all logic rising-edge.
REQ-005 Port i_reset  input  1  reset, synchronous and active-high.
REQ-006 Port i_SoP  input  1  start of picture; sampled only in IDLE.
REQ-007 Port i_imgLength  input  NB_IMAGE  side of the square image in pixels; latched on accepted i_SoP.
REQ-008 Port i_valid  input  1  one incoming pixel this cycle.
REQ-009 Port i_convReady  input  1  convolver can accept a read address this cycle.
REQ-010 Port o_writeAdd  output  NB_ADDRESS  write address within the selected bank.
REQ-011 Port o_writeEn  output  1  write strobe.
REQ-012 Port o_readAdd  output  NB_ADDRESS  read address, common to all banks.
REQ-013 Port o_bankSel  output  clog2(N_BANKS)  FILL: bank being written; RUN: bank holding the oldest column.
REQ-014 Port o_fsm2convVld  output  1  o_readAdd is valid for the convolver.
REQ-015 Port o_changeBlock  output  1  one-cycle pulse when a bank is completely written.
REQ-016 Port o_EoP  output  1  one-cycle end-of-picture pulse.
REQ-017 Port o_busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, FILL, RUN and DONE; all outputs SHALL be registered, with latency 1 cycle from the causing input.
REQ-019 IDLE, i_SoP=1, i_imgLength>=N_BANKS: latch length L, clear counters, bank pointer=0, SHALL go to FILL with initial column quota N_BANKS.
REQ-020 IDLE, i_SoP=1, i_imgLength<N_BANKS (including 0): go to DONE, with no writes and no reads.
REQ-021 FILL, each i_valid: o_writeEn=1 and o_writeAdd=current pixel index 0..L-1 SHALL appear next cycle; the cycle with i_valid=0 SHALL give o_writeEn=0.
REQ-022 FILL, valid at index L-1: index wraps to 0, o_changeBlock pulses, bank pointer advances modulo N_BANKS, and the quota decrements.
REQ-023 FILL, quota reaches 0: go to RUN with readAdd=0.
REQ-024 RUN: each cycle with ready asserted, issue o_readAdd=index and o_fsm2convVld=1, then increment the index; with ready low, hold o_readAdd and drive o_fsm2convVld=0.
REQ-025 RUN, issue of index L-1: the output column count increments; if count==L-N_BANKS+1 go to DONE, else go to FILL with quota 1 and write bank = oldest bank.
REQ-026 DONE: o_EoP=1 for exactly one cycle, o_busy deasserts, then go to IDLE.
REQ-027 i_SoP outside IDLE SHALL be ignored; i_valid outside FILL SHALL be ignored (no write).
REQ-028 i_imgLength changes after latch SHALL have no effect until the next accepted i_SoP.
REQ-029 Addresses SHALL be zero-extended from NB_IMAGE to NB_ADDRESS; the constraint L<=2^NB_ADDRESS is the integrator's responsibility.

Reset
REQ-030 i_reset=1 at any edge, including mid-FILL or mid-RUN: next state IDLE, all outputs 0, counters and bank pointer 0; a partial picture is discarded with no o_EoP.
REQ-031 Reset SHALL take priority over i_SoP, i_valid and i_convReady in the same cycle.

Configuration
REQ-032 Macro CONV_ADDR_FSM_BACKPRESSURE_EN defined: i_convReady gates RUN issue as per REQ-024.
REQ-033 Macro CONV_ADDR_FSM_BACKPRESSURE_EN undefined: i_convReady SHALL be ignored and treated as 1, so RUN issues one address every cycle; the port SHALL remain present.

Verification
REQ-034 N_BANKS=3, L=4, continuous i_valid, ready=1 -> 12 writes at addresses 0,1,2,3 for each of banks 0,1,2; o_changeBlock pulses 3 times; then 4 reads 0..3 with o_bankSel=0; then 4 writes to bank 0; then 4 reads with o_bankSel=1; then one o_EoP pulse.
REQ-035 i_valid toggling every other cycle, L=15 -> o_writeEn mirrors i_valid delayed 1 cycle; o_writeAdd advances only on valid.
REQ-036 i_SoP with i_imgLength=2 and N_BANKS=3 -> o_EoP 2 cycles later; o_writeEn and o_fsm2convVld never asserted.
REQ-037 With BACKPRESSURE_EN, i_convReady low for 3 cycles at readAdd=2 -> o_readAdd held at 2 with o_fsm2convVld=0 for those 3 cycles, then resumes at 2.
REQ-038 i_reset pulsed mid-RUN, then a new i_SoP with L=4 -> outputs 0 after reset, no o_EoP from the aborted picture; the second picture completes as in REQ-034.
